// File: rtl/rv_exec_pkg.sv
// Shared constants, ALU codes and control bundle for the exec stage.
// Imported by rv_decode, rv_alu and rv_exec_unit.
package rv_exec_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 6;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;
    localparam logic [6:0] OP_BRCH = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD   = 6'd0,
        ALU_SUB   = 6'd1,
        ALU_AND   = 6'd2,
        ALU_OR    = 6'd3,
        ALU_XOR   = 6'd4,
        ALU_SLL   = 6'd5,
        ALU_SRL   = 6'd6,
        ALU_SRA   = 6'd7,
        ALU_SLT   = 6'd8,
        ALU_SLTU  = 6'd9,
        ALU_PASSB = 6'd10,
        ALU_NOP   = 6'd63
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_ctr;
        logic    alusrc;
        logic    regwrite;
        logic    memread;
        logic    memwrite;
        logic    memtoreg;
        logic    branch;
        logic    illegal;
    } ctrl_t;

    // alt picks SUB / SRA; callers gate it so ADDI never becomes SUB.
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3,
                                          input logic       alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational 32-bit ALU.
// Ports: op, a, b in; result out (NOP and unknown codes give 0).
module rv_alu
    import rv_exec_pkg::*;
(
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);
    logic [4:0] sh;

    assign sh = b[4:0];

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLL:   result = a << sh;
            ALU_SRL:   result = a >> sh;
            ALU_SRA:   result = $signed(a) >>> sh;
            ALU_SLT:   result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {31'b0, a < b};
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/rv_decode.sv
// Combinational decoder: instruction -> control bundle and immediates.
// Ports: instruction in; ctrl, imm (operand-B immediate), branch_imm out.
module rv_decode
    import rv_exec_pkg::*;
(
    input  logic [XLEN-1:0] instruction,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] branch_imm
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic r_ok;
    logic i_ok;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25],
                    instruction[11:7]};
    assign branch_imm = {{19{instruction[31]}}, instruction[31],
                         instruction[7], instruction[30:25],
                         instruction[11:8], 1'b0};

    // Alternate funct7 only exists for SUB and SRA.
    assign r_ok = (funct7 == F7_BASE) ||
                  (funct7 == F7_ALT &&
                   (funct3 == F3_ADD || funct3 == F3_SR));
    // Only shift-immediates constrain the upper bits.
    assign i_ok = (funct3 == F3_SLL) ? (funct7 == F7_BASE) :
                  (funct3 == F3_SR)  ? (funct7 == F7_BASE ||
                                        funct7 == F7_ALT) : 1'b1;

    always_comb begin
        ctrl         = '0;
        ctrl.alu_ctr = ALU_NOP;
        ctrl.illegal = 1'b1;
        imm          = '0;
        unique case (1'b1)
            (opcode == OP_R && r_ok): begin
                ctrl.illegal  = 1'b0;
                ctrl.regwrite = 1'b1;
                ctrl.alu_ctr  = f3_to_alu(funct3, instruction[30]);
            end
            (opcode == OP_IALU && i_ok): begin
                ctrl.illegal  = 1'b0;
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.alu_ctr  = f3_to_alu(funct3,
                    (funct3 == F3_SR) && instruction[30]);
                imm = imm_i;
            end
            (opcode == OP_LOAD && funct3 == F3_W): begin
                ctrl.illegal  = 1'b0;
                ctrl.alu_ctr  = ALU_ADD;
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                imm = imm_i;
            end
            (opcode == OP_STOR && funct3 == F3_W): begin
                ctrl.illegal  = 1'b0;
                ctrl.alu_ctr  = ALU_ADD;
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                imm = imm_s;
            end
            (opcode == OP_BRCH && funct3 == F3_ADD): begin
                ctrl.illegal = 1'b0;
                ctrl.alu_ctr = ALU_SUB;
                ctrl.branch  = 1'b1;
            end
            (opcode == OP_LUI): begin
                ctrl.illegal  = 1'b0;
                ctrl.alu_ctr  = ALU_PASSB;
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                imm = {instruction[31:12], 12'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_exec_unit.sv
// Registered decode + execute stage: decode, operand-B mux, ALU, out regs.
// Ports: clk, reset(n), in_valid, instruction, rs1/rs2_data in; results out.
module rv_exec_unit
    import rv_exec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   instruction,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              out_valid,
    output logic [XLEN-1:0]   alu_result,
    output logic              zero,
    output logic [CTRL_W-1:0] alu_ctr,
    output logic              alusrc,
    output logic              regwrite,
    output logic              memread,
    output logic              memwrite,
    output logic              memtoreg,
    output logic              branch,
    output logic [4:0]        rd,
    output logic [XLEN-1:0]   store_data,
    output logic [XLEN-1:0]   branch_imm,
    output logic              illegal
);
    ctrl_t           ctrl_d;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] bimm_d;
    logic [XLEN-1:0] opb_d;
    logic [XLEN-1:0] res_d;

    logic              valid_q;
    logic [XLEN-1:0]   res_q;
    logic              zero_q;
    logic [CTRL_W-1:0] ctr_q;
    logic              alusrc_q;
    logic              rw_q;
    logic              mr_q;
    logic              mw_q;
    logic              mtr_q;
    logic              br_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   sd_q;
    logic [XLEN-1:0]   bimm_q;
    logic              ill_q;

    rv_decode u_dec (
        .instruction (instruction),
        .ctrl        (ctrl_d),
        .imm         (imm_d),
        .branch_imm  (bimm_d)
    );

    assign opb_d = ctrl_d.alusrc ? imm_d : rs2_data;

    rv_alu u_alu (
        .op     (ctrl_d.alu_ctr),
        .a      (rs1_data),
        .b      (opb_d),
        .result (res_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            ctr_q    <= '0;
            alusrc_q <= 1'b0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            mtr_q    <= 1'b0;
            br_q     <= 1'b0;
            rd_q     <= '0;
            sd_q     <= '0;
            bimm_q   <= '0;
            ill_q    <= 1'b0;
        end else if (in_valid) begin
            valid_q  <= 1'b1;
            res_q    <= res_d;
            zero_q   <= (res_d == '0);
            ctr_q    <= ctrl_d.alu_ctr;
            alusrc_q <= ctrl_d.alusrc;
            rw_q     <= ctrl_d.regwrite;
            mr_q     <= ctrl_d.memread;
            mw_q     <= ctrl_d.memwrite;
            mtr_q    <= ctrl_d.memtoreg;
            br_q     <= ctrl_d.branch;
            rd_q     <= instruction[11:7];
            sd_q     <= rs2_data;
            bimm_q   <= bimm_d;
            ill_q    <= ctrl_d.illegal;
        end else begin
            // Bubble: kill side-effecting controls, hold the data path.
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            mtr_q   <= 1'b0;
            br_q    <= 1'b0;
        end
    end

    assign out_valid  = valid_q;
    assign alu_result = res_q;
    assign zero       = zero_q;
    assign alu_ctr    = ctr_q;
    assign alusrc     = alusrc_q;
    assign regwrite   = rw_q;
    assign memread    = mr_q;
    assign memwrite   = mw_q;
    assign memtoreg   = mtr_q;
    assign branch     = br_q;
    assign rd         = rd_q;
    assign store_data = sd_q;
    assign branch_imm = bimm_q;
    assign illegal    = ill_q;

endmodule

// File: tb/tb_rv_exec_unit.sv
// Randomized self-checking bench for rv_exec_unit.
// Mnemonic-level reference model; directed vectors then random traffic.
module tb_rv_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_valid;
    logic [31:0] alu_result;
    logic        zero;
    logic [5:0]  alu_ctr;
    logic        alusrc, regwrite, memread, memwrite, memtoreg, branch;
    logic [4:0]  rd;
    logic [31:0] store_data, branch_imm;
    logic        illegal;

    int total = 0;
    int bad = 0;

    logic        e_valid, e_zero, e_alusrc, e_rw, e_mr, e_mw, e_mtr;
    logic        e_br, e_ill;
    logic [31:0] e_res, e_sd, e_bimm;
    logic [5:0]  e_ctr;
    logic [4:0]  e_rd;

    always #5 clk = ~clk;

    rv_exec_unit dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .instruction (instruction),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .out_valid   (out_valid),
        .alu_result  (alu_result),
        .zero        (zero),
        .alu_ctr     (alu_ctr),
        .alusrc      (alusrc),
        .regwrite    (regwrite),
        .memread     (memread),
        .memwrite    (memwrite),
        .memtoreg    (memtoreg),
        .branch      (branch),
        .rd          (rd),
        .store_data  (store_data),
        .branch_imm  (branch_imm),
        .illegal     (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        e_valid = 0; e_res = 0; e_zero = 0; e_ctr = 0; e_alusrc = 0;
        e_rw = 0; e_mr = 0; e_mw = 0; e_mtr = 0; e_br = 0;
        e_rd = 0; e_sd = 0; e_bimm = 0; e_ill = 0;
    endtask

    // Name the instruction first, then derive everything from the name.
    task automatic model(input logic v, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b2);
        string m;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] ii, si, ui, b;
        int unsigned shamt;
        if (!v) begin
            e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_mtr = 0; e_br = 0;
            return;
        end
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        ii = 32'($signed(ins) >>> 20);
        si = {ii[31:5], ins[11:7]};
        ui = ins & 32'hFFFF_F000;
        m = "ill";
        if (op == 7'h33) begin
            if (f7 == 0) begin
                case (f3)
                    0: m = "add"; 1: m = "sll"; 2: m = "slt"; 3: m = "sltu";
                    4: m = "xor"; 5: m = "srl"; 6: m = "or";  7: m = "and";
                endcase
            end else if (f7 == 7'h20 && f3 == 0) m = "sub";
            else if (f7 == 7'h20 && f3 == 5) m = "sra";
        end else if (op == 7'h13) begin
            case (f3)
                0: m = "addi"; 2: m = "slti"; 3: m = "sltiu"; 4: m = "xori";
                6: m = "ori";  7: m = "andi";
                1: if (f7 == 0) m = "slli";
                5: if (f7 == 0) m = "srli"; else if (f7 == 7'h20) m = "srai";
            endcase
        end else if (op == 7'h03 && f3 == 2) m = "lw";
        else if (op == 7'h23 && f3 == 2) m = "sw";
        else if (op == 7'h63 && f3 == 0) m = "beq";
        else if (op == 7'h37) m = "lui";

        case (m)
            "add","sub","sll","slt","sltu","xor","srl","sra","or","and",
            "beq": b = b2;
            "sw": b = si;
            "lui": b = ui;
            default: b = ii;
        endcase
        shamt = b % 32;

        e_alusrc = !(m inside {"add","sub","sll","slt","sltu","xor","srl",
                               "sra","or","and","beq","ill"});
        e_rw  = !(m inside {"sw","beq","ill"});
        e_mr  = (m == "lw");
        e_mtr = (m == "lw");
        e_mw  = (m == "sw");
        e_br  = (m == "beq");
        e_ill = (m == "ill");
        case (m)
            "add","addi","lw","sw": begin e_ctr = 0; e_res = a + b; end
            "sub","beq": begin e_ctr = 1; e_res = a - b; end
            "and","andi": begin e_ctr = 2; e_res = a & b; end
            "or","ori":   begin e_ctr = 3; e_res = a | b; end
            "xor","xori": begin e_ctr = 4; e_res = a ^ b; end
            "sll","slli": begin e_ctr = 5; e_res = a * (2**shamt); end
            "srl","srli": begin e_ctr = 6; e_res = a / (2**shamt); end
            "sra","srai": begin
                e_ctr = 7;
                e_res = a[31] ? ~((~a) / (2**shamt)) : a / (2**shamt);
            end
            "slt","slti": begin
                e_ctr = 8; e_res = (int'(a) < int'(b)) ? 1 : 0;
            end
            "sltu","sltiu": begin
                e_ctr = 9; e_res = ({1'b0,a} < {1'b0,b}) ? 1 : 0;
            end
            "lui": begin e_ctr = 10; e_res = b; end
            default: begin e_ctr = 63; e_res = 0; end
        endcase
        e_valid = 1;
        e_zero  = (e_res == 0);
        e_rd    = ins[11:7];
        e_sd    = b2;
        e_bimm  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                   ins[11:8], 1'b0};
    endtask

    task automatic check_all();
        check("valid", 32'(out_valid), 32'(e_valid));
        check("result", alu_result, e_res);
        check("zero", 32'(zero), 32'(e_zero));
        check("alu_ctr", 32'(alu_ctr), 32'(e_ctr));
        check("alusrc", 32'(alusrc), 32'(e_alusrc));
        check("regwrite", 32'(regwrite), 32'(e_rw));
        check("memread", 32'(memread), 32'(e_mr));
        check("memwrite", 32'(memwrite), 32'(e_mw));
        check("memtoreg", 32'(memtoreg), 32'(e_mtr));
        check("branch", 32'(branch), 32'(e_br));
        check("rd", 32'(rd), 32'(e_rd));
        check("store_data", store_data, e_sd);
        check("branch_imm", branch_imm, e_bimm);
        check("illegal", 32'(illegal), 32'(e_ill));
    endtask

    task automatic apply(input logic v, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v; instruction = ins; rs1_data = a; rs2_data = b;
        @(posedge clk);
        model(v, ins, a, b);
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  f7;
        int k;
        w = $urandom;
        k = $urandom_range(0, 3);
        f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : w[31:25];
        case ($urandom_range(0, 7))
            0, 7: w = {f7, w[24:7], 7'h33};
            1: w = {(w[13:12] == 2'b01) ? f7 : w[31:25], w[24:7], 7'h13};
            2: w = {w[31:15], (k == 3) ? w[14:12] : 3'b010, w[11:7], 7'h03};
            3: w = {w[31:15], (k == 3) ? w[14:12] : 3'b010, w[11:7], 7'h23};
            4: w = {w[31:15], (k == 3) ? w[14:12] : 3'b000, w[11:7], 7'h63};
            5: w = {w[31:7], 7'h37};
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] a, b, ins;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        apply(1, 32'h002081B3, 5, 7);
        check("add_res", alu_result, 12);
        apply(1, 32'h402081B3, 9, 9);
        check("sub_zero", 32'(zero), 1);
        apply(1, 32'hFFF00093, 0, 0);
        check("addi_res", alu_result, 32'hFFFF_FFFF);
        apply(1, 32'h4040D093, 32'h8000_0000, 0);
        check("srai_res", alu_result, 32'hF800_0000);
        apply(1, 32'h00812283, 32'h100, 0);
        check("lw_res", alu_result, 32'h108);
        apply(1, 32'h00512623, 32'h100, 32'hAB);
        check("sw_res", alu_result, 32'h10C);
        apply(1, 32'h00208063, 3, 3);
        check("beq_br", 32'(branch), 1);
        apply(1, 32'hFFFFFFFF, 1, 2);
        check("ill_flag", 32'(illegal), 1);
        apply(1, 32'h002081B3, 5, 7);

        #2 reset = 1'b0;
        #1;
        model_clear();
        check_all();
        @(negedge clk);
        reset = 1'b1;

        apply(1, 32'h00812283, 32'h100, 0);
        apply(0, 32'h002081B3, 5, 7);
        check("bubble_rw", 32'(regwrite), 0);

        for (int i = 0; i < 400; i++) begin
            ins = rand_instr();
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            apply($urandom_range(0, 4) != 0, ins, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_exec_unit.md
Name: rv_exec_unit

Overview:
- Registered decode + execute stage for a single-cycle-issue RV32I-subset core.
- Decodes a 32-bit instruction into control signals and an ALU operation code.
- Selects operand B (register or sign-extended immediate) and computes the ALU result and zero flag.
- All results are presented one clock later, feeding the memory/writeback logic and the PC branch logic.

Parameters:
- XLEN, 32, datapath width (only 32 is supported).
- CTRL_W, 6, width of the ALU control code.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  instruction/operands valid this cycle.
- instruction  input  32  raw instruction word.
- rs1_data  input  32  value of register instruction[19:15].
- rs2_data  input  32  value of register instruction[24:20].
- out_valid  output  1  registered copy of in_valid.
- alu_result  output  32  ALU result.
- zero  output  1  1 when the unregistered ALU result is 0 (registered with it).
- alu_ctr  output  6  decoded ALU operation.
- alusrc  output  1  1 means operand B is the immediate.
- regwrite, memread, memwrite, memtoreg, branch  output  1 each  control signals.
- rd  output  5  instruction[11:7].
- store_data  output  32  rs2_data, for stores.
- branch_imm  output  32  sign-extended B-type offset.
- illegal  output  1  unsupported opcode/funct combination.

Behaviour:
- Latency: 1 cycle. Inputs are sampled at a rising edge of clk; all outputs update at that edge.
- Outputs are registered only when in_valid=1. When in_valid=0, out_valid=0 and every control output (regwrite, memread, memwrite, branch, memtoreg) is forced to 0; the data outputs hold their previous values.
- Reset (reset=0): immediately clears every output to 0 (alu_ctr=0, out_valid=0), independent of clk. Deassertion is only released at a clock edge by the registers' next sample. Reset mid-operation drops the in-flight result.
- alu_ctr codes:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
  - PASSB=10 (result = operand B).
  - NOP=63 (result = 0).
- Decode by opcode[6:0]:
  - 0110011 R-type: alusrc=0, regwrite=1. funct3/funct7[5] select ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. Other funct7 values are illegal.
  - 0010011 I-ALU: alusrc=1, regwrite=1. ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI; instruction[30] selects SRA. Shift encodings with other funct7 bits are illegal.
  - 0000011 LW (funct3=010): ADD, alusrc=1, memread=1, memtoreg=1, regwrite=1.
  - 0100011 SW (funct3=010): ADD, alusrc=1, memwrite=1, S-type immediate.
  - 1100011 BEQ (funct3=000): SUB, alusrc=0, branch=1.
  - 0110111 LUI: PASSB, alusrc=1, immediate = {instruction[31:12], 12'b0}, regwrite=1.
- Any other encoding: illegal=1, alu_ctr=NOP, all other controls 0, result 0.
- Immediates are sign-extended from bit 31:
  - I-type: [31:20].
  - S-type: {[31:25],[11:7]}.
  - B-type: {[31],[7],[30:25],[11:8],1'b0}.
- Arithmetic: ADD/SUB wrap modulo 2^32 with no overflow flag.
- Shifts use operand B[4:0] only. SRA replicates bit 31.
- SLT compares signed, SLTU unsigned; result is 0 or 1.
- zero = (alu_result == 0) for every operation, including NOP.

Decomposition:
- Package rv_exec_pkg holds the opcode constants, funct3/funct7 constants, alu_ctr codes, and a control-bundle struct typedef.
- Sub-modules:
  - rv_decode: combinational decode plus immediate generation.
  - rv_alu: combinational ALU.
- The top level instantiates both, adds the operand-B mux, and registers all outputs.

Test Plan:
- Apply 0x002081B3 (add x3,x1,x2) with rs1=5, rs2=7 -> next edge: alu_result=12, zero=0, regwrite=1, rd=3, alu_ctr=0.
- Apply 0x402081B3 (sub) with rs1=rs2=9 -> alu_result=0, zero=1, alu_ctr=1.
- Apply 0xFFF00093 (addi x1,x0,-1) with rs1=0 -> alu_result=0xFFFFFFFF, alusrc=1. Then apply 0x4040D093 (srai x1,x1,4) with rs1=0x80000000 -> 0xF8000000.
- Apply 0x00812283 (lw x5,8(x2)) with rs1=0x100 -> alu_result=0x108, memread=memtoreg=regwrite=1. Apply 0x00512623 (sw) with rs1=0x100, rs2=0xAB -> alu_result=0x10C, memwrite=1, store_data=0xAB, regwrite=0.
- Apply 0x00208063 (beq) with rs1=rs2=3 -> branch=1, zero=1. Apply 0xFFFFFFFF -> illegal=1, all controls 0, zero=1.
- Assert reset=0 between edges while outputs are non-zero -> all outputs 0 immediately. Apply in_valid=0 -> out_valid=0 and controls 0.
